multdiv_shift_engine: RTL and testbench

//   Parametrised shift register + step sequencer for iterative multdiv datapaths (Booth radix-4, restoring div).

---
 rtl/multdiv_shift_engine_pkg.sv | 20 ++
 rtl/multdiv_shift_engine_if.sv | 30 +++
 rtl/multdiv_shift_engine_shift_step_unit.sv | 24 ++
 rtl/multdiv_shift_engine.sv | 113 +++++++++++
 tb/tb_multdiv_shift_engine.sv | 135 +++++++++++++
 5 files changed

// File: rtl/multdiv_shift_engine_pkg.sv
// Shared op encodings and sequencer states for the multdiv shift engine.
// Optional feature macro used by the engine: SHIFT_ENGINE_STICKY_EN.
package multdiv_shift_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [1:0] op);
    return (op == OP_SRA) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/multdiv_shift_engine_if.sv
// Control/data bundle between the multdiv control FSM (master) and the shift engine (slave).
// The sticky signal exists only when SHIFT_ENGINE_STICKY_EN is defined.
interface multdiv_shift_engine_if #(
  parameter int WIDTH = 66,
  parameter int CNT_W = 6
);
  logic             start;
  logic [CNT_W-1:0] start_count;
  logic [1:0]       op;
  logic [WIDTH-1:0] d;
  logic             shl_bit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic             op_err;
`ifdef SHIFT_ENGINE_STICKY_EN
  logic             sticky;

  modport master (output start, start_count, op, d, shl_bit,
                  input  q, busy, done, remaining, op_err, sticky);
  modport slave  (input  start, start_count, op, d, shl_bit,
                  output q, busy, done, remaining, op_err, sticky);
`else
  modport master (output start, start_count, op, d, shl_bit,
                  input  q, busy, done, remaining, op_err);
  modport slave  (input  start, start_count, op, d, shl_bit,
                  output q, busy, done, remaining, op_err);
`endif
endinterface

// File: rtl/multdiv_shift_engine_shift_step_unit.sv
// Combinational next-register value for one data op; HOLD and LOAD pass q through
// (LOAD data is muxed in by the sequencer).
module shift_step_unit
  import multdiv_shift_pkg::*;
#(
  parameter int WIDTH   = 66,
  parameter int SRA_AMT = 2
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       op,
  input  logic             shl_bit,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SRA:  q_next = $signed(q) >>> SRA_AMT;
      OP_SHL:  q_next = {q[WIDTH-2:0], shl_bit};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/multdiv_shift_engine.sv
// Shift register plus step sequencer for iterative multiply/divide datapaths.
// Define SHIFT_ENGINE_STICKY_EN to track the OR of all bits lost to SRA steps.
//
// state | meaning
// IDLE  | accepts LOAD and start; shift ops rejected
// RUN   | each SRA/SHL is one step; LOAD rejected
// DONE  | one-cycle done pulse, then back to IDLE
module multdiv_shift_engine
  import multdiv_shift_pkg::*;
#(
  parameter int WIDTH   = 66,
  parameter int SRA_AMT = 2,
  parameter int CNT_W   = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  multdiv_shift_engine_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             done;
  logic             op_err;

  shift_step_unit #(.WIDTH(WIDTH), .SRA_AMT(SRA_AMT)) u_step (
    .q       (q),
    .op      (bus.op),
    .shl_bit (bus.shl_bit),
    .q_next  (q_next)
  );

`ifdef SHIFT_ENGINE_STICKY_EN
  logic sticky;
  assign bus.sticky = sticky;
`endif

  assign bus.q         = q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.remaining = remaining;
  assign bus.op_err    = op_err;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      q         <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_err    <= 1'b0;
`ifdef SHIFT_ENGINE_STICKY_EN
      sticky    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          op_err <= is_shift(bus.op);
          if (bus.op == OP_LOAD) begin
            q <= bus.d;
`ifdef SHIFT_ENGINE_STICKY_EN
            sticky <= 1'b0;
`endif
          end
          if (bus.start) begin
            remaining <= bus.start_count;
`ifdef SHIFT_ENGINE_STICKY_EN
            sticky    <= 1'b0;
`endif
            if (bus.start_count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          op_err <= (bus.op == OP_LOAD);
          if (is_shift(bus.op)) begin
            q <= q_next;
`ifdef SHIFT_ENGINE_STICKY_EN
            if (bus.op == OP_SRA) sticky <= sticky | (|q[SRA_AMT-1:0]);
`endif
            // remaining is never 0 in RUN, but guard so it cannot wrap
            if (remaining <= CNT_W'(1)) begin
              remaining <= '0;
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        DONE: begin
          op_err <= (bus.op != OP_HOLD);
          done   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_shift_engine.sv
// Scoreboard bench for multdiv_shift_engine: each driven cycle pushes its expected outputs,
// which are popped and compared one cycle later.
module tb_multdiv_shift_engine;

  localparam logic [1:0] H = 2'b00;
  localparam logic [1:0] L = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] S = 2'b11;
  localparam logic [65:0] Z    = 66'h0;
  localparam logic [65:0] NEG  = 66'h2_0000_0000_0000_0000;
  localparam logic [65:0] NEGS = 66'h3_8000_0000_0000_0000;

  typedef struct {
    logic [65:0] q;
    logic        busy;
    logic        done;
    logic [5:0]  rem;
    logic        err;
    logic        sticky;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  multdiv_shift_engine_if #(.WIDTH(66), .CNT_W(6)) bus ();

  multdiv_shift_engine #(.WIDTH(66), .SRA_AMT(2), .CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic [1:0] o, input logic [65:0] dv, input logic sb,
                     input logic st, input logic [5:0] cnt,
                     input logic [65:0] eq, input logic eb, input logic ed, input logic [5:0] er,
                     input logic ee, input logic es);
    exp_t e;
    @(negedge clk);
    clr = c; bus.op = o; bus.d = dv; bus.shl_bit = sb; bus.start = st; bus.start_count = cnt;
    e.q = eq; e.busy = eb; e.done = ed; e.rem = er; e.err = ee; e.sticky = es;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 66'd1, 66'd0);
    end else begin
      e = sb_q.pop_front();
      chk("q", bus.q, e.q);
      chk("busy", 66'(bus.busy), 66'(e.busy));
      chk("done", 66'(bus.done), 66'(e.done));
      chk("remaining", 66'(bus.remaining), 66'(e.rem));
      chk("op_err", 66'(bus.op_err), 66'(e.err));
`ifdef SHIFT_ENGINE_STICKY_EN
      chk("sticky", 66'(bus.sticky), 66'(e.sticky));
`endif
    end
  endtask

  initial begin
    bus.op = H; bus.d = Z; bus.shl_bit = 1'b0; bus.start = 1'b0; bus.start_count = 6'd0;
    //   clr op d      sb st cnt | q        busy done rem err sticky
    cyc(1, H, Z,     0, 0, 0,    Z,       0, 0, 0, 0, 0);
    cyc(1, R, Z,     0, 1, 5,    Z,       0, 0, 0, 0, 0);

    // SRA by 2, two steps
    cyc(0, L, 66'h10, 0, 0, 0,   66'h10,  0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 1, 2,    66'h10,  1, 0, 2, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    66'h4,   1, 0, 1, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    66'h1,   0, 1, 0, 0, 0);
    cyc(0, H, Z,     0, 0, 0,    66'h1,   0, 0, 0, 0, 0);

    // sign fill
    cyc(0, L, NEG,   0, 0, 0,    NEG,     0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 1, 1,    NEG,     1, 0, 1, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    NEGS,    0, 1, 0, 0, 0);
    cyc(0, H, Z,     0, 0, 0,    NEGS,    0, 0, 0, 0, 0);

    // SHL with inserted bits 1,0,1
    cyc(0, L, 66'h1, 0, 0, 0,    66'h1,   0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 1, 3,    66'h1,   1, 0, 3, 0, 0);
    cyc(0, S, Z,     1, 0, 0,    66'h3,   1, 0, 2, 0, 0);
    cyc(0, S, Z,     0, 0, 0,    66'h6,   1, 0, 1, 0, 0);
    cyc(0, S, Z,     1, 0, 0,    66'hD,   0, 1, 0, 0, 0);
    cyc(0, H, Z,     0, 0, 0,    66'hD,   0, 0, 0, 0, 0);

    // zero-count start
    cyc(0, H, Z,     0, 1, 0,    66'hD,   0, 1, 0, 0, 0);
    cyc(0, H, Z,     0, 0, 0,    66'hD,   0, 0, 0, 0, 0);

    // illegal ops and ignored start
    cyc(0, H, Z,     0, 1, 2,    66'hD,   1, 0, 2, 0, 0);
    cyc(0, H, Z,     0, 1, 5,    66'hD,   1, 0, 2, 0, 0);
    cyc(0, L, 66'hFFFF, 0, 0, 0, 66'hD,   1, 0, 2, 1, 0);
    cyc(0, H, Z,     0, 0, 0,    66'hD,   1, 0, 2, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    66'h3,   1, 0, 1, 0, 1);
    cyc(0, R, Z,     0, 0, 0,    66'h0,   0, 1, 0, 0, 1);
    cyc(0, S, Z,     1, 0, 0,    66'h0,   0, 0, 0, 1, 1);
    cyc(0, L, 66'h5, 0, 0, 0,    66'h5,   0, 0, 0, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    66'h5,   0, 0, 0, 1, 0);
    cyc(0, H, Z,     0, 0, 0,    66'h5,   0, 0, 0, 0, 0);

    // clr mid-run, then max count and clr
    cyc(0, L, 66'h7, 0, 0, 0,    66'h7,   0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 1, 4,    66'h7,   1, 0, 4, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    66'h1,   1, 0, 3, 0, 1);
    cyc(1, R, Z,     0, 0, 0,    Z,       0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 0, 0,    Z,       0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 1, 63,   Z,       1, 0, 63, 0, 0);
    cyc(1, H, Z,     0, 0, 0,    Z,       0, 0, 0, 0, 0);

    // sticky capture of shifted-out ones
    cyc(0, L, 66'h3, 0, 0, 0,    66'h3,   0, 0, 0, 0, 0);
    cyc(0, H, Z,     0, 1, 1,    66'h3,   1, 0, 1, 0, 0);
    cyc(0, R, Z,     0, 0, 0,    66'h0,   0, 1, 0, 0, 1);
    cyc(0, H, Z,     0, 0, 0,    66'h0,   0, 0, 0, 0, 1);

    chk("scoreboard_drained", 66'(sb_q.size()), 66'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
